// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: fetch/decode/execute/memory/writeback sequencing.
// Define INSN_TRAP_EN to route unrecognised opcodes through a TRAP state.
module mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pc_en,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    TRAP    = 4'd12
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    pc_src     = 2'd0;

    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        // PC and IR load only on the completing cycle, so a stalled fetch advances PC once.
        pc_en     = mem_ready;
        ir_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        if (op == OP_LW || op == OP_SW) state_d = MEMADR;
        else if (op == OP_RTYPE)        state_d = RTYPEEX;
        else if (op == OP_BEQ)          state_d = BEQEX;
        else if (op == OP_ADDI)         state_d = ADDIEX;
        else if (op == OP_J)            state_d = JEX;
`ifdef INSN_TRAP_EN
        else                            state_d = TRAP;
`else
        else                            state_d = FETCH;
`endif
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = RTYPEWB;
      end
      RTYPEWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd1;
        pc_src    = 2'd1;
        pc_en     = zero;
        state_d   = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      JEX: begin
        pc_src  = 2'd2;
        pc_en   = 1'b1;
        state_d = FETCH;
      end
`ifdef INSN_TRAP_EN
      TRAP: begin
        pc_src  = 2'd3;
        pc_en   = 1'b1;
        state_d = FETCH;
      end
`endif
      default: state_d = FETCH;
    endcase

    // Outputs are forced quiet for the whole time reset is held, not just at the edge.
    if (!reset) begin
      mem_req    = 1'b0;
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = 2'd0;
      pc_src     = 2'd0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: expected state+control vector queued per driven cycle.
module tb_mc_control_fsm;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BAD   = 6'h3F;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, pc_en, ir_write, iord, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int passed = 0;
  int total  = 0;
  logic [18:0] sb [$];
  logic [18:0] exp_v;
  wire  [18:0] obs_v = {state, mem_req, pc_en, ir_write, iord, mem_write, reg_write,
                        reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .pc_en(pc_en), .ir_write(ir_write), .iord(iord),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .state(state)
  );

  always #5 clk = ~clk;

  // Reference control table, written straight from the state descriptions.
  function automatic logic [18:0] exp_vec(input logic [3:0] st, input logic z,
                                          input logic rdy, input logic rst);
    logic req, pce, irw, io, mw, rw, rd, m2r, sa;
    logic [1:0] sbv, aop, psrc;
    {req, pce, irw, io, mw, rw, rd, m2r, sa, sbv, aop, psrc} = '0;
    case (st)
      4'd0:  begin req = 1; pce = rdy; irw = rdy; sbv = 2'd1; end
      4'd1:  sbv = 2'd3;
      4'd2:  begin sa = 1; sbv = 2'd2; end
      4'd3:  begin req = 1; io = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin req = 1; io = 1; mw = 1; end
      4'd6:  begin sa = 1; aop = 2'd2; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; aop = 2'd1; psrc = 2'd1; pce = z; end
      4'd9:  begin sa = 1; sbv = 2'd2; end
      4'd10: rw = 1;
      4'd11: begin psrc = 2'd2; pce = 1; end
      4'd12: begin psrc = 2'd3; pce = 1; end
      default: ;
    endcase
    if (!rst) exp_vec = '0;
    else      exp_vec = {st, req, pce, irw, io, mw, rw, rd, m2r, sa, sbv, aop, psrc};
  endfunction

  task automatic drive(input logic rst, input logic [5:0] o, input logic z,
                       input logic rdy, input logic [3:0] st);
    reset = rst; op = o; zero = z; mem_ready = rdy;
    sb.push_back(exp_vec(st, z, rdy, rst));
  endtask

  task automatic test_reset();
    logic [3:0] st [5]  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd11};
    logic       rst [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(rst[i], OP_J, 1'b1, 1'b1, st[i]);
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (obs_v !== exp_v) $display("FAIL reset cyc%0d got state=%0d ctl=%h required state=%0d ctl=%h", i, obs_v[18:15], obs_v[14:0], exp_v[18:15], exp_v[14:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    logic [3:0] st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, OP_LW, 1'b0, 1'b1, st[i]);
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (obs_v !== exp_v) $display("FAIL lw cyc%0d got state=%0d ctl=%h required state=%0d ctl=%h", i, obs_v[18:15], obs_v[14:0], exp_v[18:15], exp_v[14:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch_stall();
    logic [3:0] st  [7] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd6, 4'd7};
    logic       rdy [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, OP_RTYPE, 1'b0, rdy[i], st[i]);
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (obs_v !== exp_v) $display("FAIL fetch_stall cyc%0d got state=%0d ctl=%h required state=%0d ctl=%h", i, obs_v[18:15], obs_v[14:0], exp_v[18:15], exp_v[14:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    logic [3:0] st [6] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd8};
    logic       z  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, OP_BEQ, z[i], 1'b1, st[i]);
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (obs_v !== exp_v) $display("FAIL beq cyc%0d got state=%0d ctl=%h required state=%0d ctl=%h", i, obs_v[18:15], obs_v[14:0], exp_v[18:15], exp_v[14:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_stall();
    logic [3:0] st  [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5};
    logic       rdy [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, OP_SW, 1'b0, rdy[i], st[i]);
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (obs_v !== exp_v) $display("FAIL sw_stall cyc%0d got state=%0d ctl=%h required state=%0d ctl=%h", i, obs_v[18:15], obs_v[14:0], exp_v[18:15], exp_v[14:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] st [7] = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd1, 4'd11};
    logic [5:0] o  [7] = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI, OP_J, OP_J, OP_J};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, o[i], 1'b1, 1'b1, st[i]);
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (obs_v !== exp_v) $display("FAIL addi_j cyc%0d got state=%0d ctl=%h required state=%0d ctl=%h", i, obs_v[18:15], obs_v[14:0], exp_v[18:15], exp_v[14:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bad_op();
`ifdef INSN_TRAP_EN
    localparam int N = 3;
    logic [3:0] st [N] = '{4'd0, 4'd1, 4'd12};
`else
    localparam int N = 2;
    logic [3:0] st [N] = '{4'd0, 4'd1};
`endif
    for (int i = 0; i < N; i++) begin
      drive(1'b1, OP_BAD, 1'b1, 1'b1, st[i]);
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (obs_v !== exp_v) $display("FAIL bad_op cyc%0d got state=%0d ctl=%h required state=%0d ctl=%h", i, obs_v[18:15], obs_v[14:0], exp_v[18:15], exp_v[14:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] st  [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    logic       rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OP_SW, 1'b0, rdy[i], st[i]);
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (obs_v !== exp_v) $display("FAIL reset_mid cyc%0d got state=%0d ctl=%h required state=%0d ctl=%h", i, obs_v[18:15], obs_v[14:0], exp_v[18:15], exp_v[14:0]);
      else passed++;
      if (i < 3) begin @(posedge clk); #1; end
    end
    // Drop reset between edges while stalled in MEMWR: outputs must clear at once.
    #1;
    drive(1'b0, OP_SW, 1'b0, 1'b0, 4'd5);
    #1;
    exp_v = sb.pop_front(); total++;
    if (obs_v !== exp_v) $display("FAIL reset_abort got state=%0d ctl=%h required state=%0d ctl=%h", obs_v[18:15], obs_v[14:0], exp_v[18:15], exp_v[14:0]);
    else passed++;
    @(posedge clk); #1;
    drive(1'b1, OP_SW, 1'b0, 1'b1, 4'd0);
    @(negedge clk);
    exp_v = sb.pop_front(); total++;
    if (obs_v !== exp_v) $display("FAIL reset_refetch got state=%0d ctl=%h required state=%0d ctl=%h", obs_v[18:15], obs_v[14:0], exp_v[18:15], exp_v[14:0]);
    else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; op = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_fetch_stall();
    test_beq();
    test_sw_stall();
    test_back_to_back();
    test_bad_op();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
